unsigned_16by8_div_seq: RTL and testbench
=========================================

UNSIGNED_16BY8_DIV_SEQ -- requirements
Module: unsigned_16by8_div_seq

Interface
REQ-001 SHALL have parameter W, default 8, operand width (divisor, quotient and remainder are W bits; dividend is 2W bits).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  dividend and divisor are valid.
REQ-005 SHALL have port in_ready  output  1  the block can accept an operation.
REQ-006 SHALL have port dividend  input  2W  unsigned dividend.
REQ-007 SHALL have port divisor  input  W  unsigned divisor.
REQ-008 SHALL have port out_valid  output  1  the result is valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port quotient  output  W  unsigned quotient.
REQ-011 SHALL have port remainder  output  W  unsigned remainder.
REQ-012 SHALL have port div_by_zero  output  1  the divisor was 0.
REQ-013 SHALL have port overflow  output  1  the quotient does not fit in W bits.

Function
REQ-014 SHALL implement a state machine with states IDLE, BUSY and DONE.
REQ-015 SHALL assert in_ready only in IDLE; an operation is accepted when in_valid and in_ready are both high at a clock edge.
REQ-016 On accept with divisor==0, SHALL go to DONE with quotient=all ones, remainder=dividend[W-1:0], div_by_zero=1 and overflow=0.
REQ-017 On accept with divisor!=0 and dividend[2W-1:W]>=divisor, SHALL go to DONE with quotient=all ones, remainder=0, overflow=1 and div_by_zero=0.
REQ-018 On any other accept, SHALL load the partial remainder with dividend[2W-1:W], latch dividend[W-1:0] and divisor, clear the step counter, and go to BUSY.
REQ-019 Each BUSY cycle, SHALL perform one restoring step:
- t = {partial remainder (W+1 bits), next dividend bit, MSB first};
- if t>=divisor, subtract divisor and shift in quotient bit 1; otherwise keep t and shift in 0.
REQ-020 SHALL move from BUSY to DONE after exactly W steps; out_valid SHALL rise W+1 cycles after the accept edge for normal operations and 1 cycle after it for the zero-divisor and overflow cases.
REQ-021 SHALL guarantee that quotient*divisor+remainder==dividend and remainder<divisor for every non-flagged result.
REQ-022 In DONE, SHALL hold out_valid high and keep quotient, remainder and the flags stable until out_ready is high; on that edge it SHALL return to IDLE and deassert out_valid.
REQ-023 SHALL NOT accept a new operation in the same cycle the result is consumed; in_ready rises the cycle after.
REQ-024 SHALL keep quotient, remainder and the flags at their last values while out_valid is low; they are only valid while out_valid is high.
REQ-025 SHALL ignore in_valid, dividend and divisor while in BUSY or DONE.

Reset
REQ-026 On rst high, SHALL immediately (asynchronously) go to IDLE and set in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, and clear all internal registers.
REQ-027 A reset during BUSY or DONE SHALL abort the operation with no result produced; after rst is released, the first accept SHALL behave as from power-up.

Structure
REQ-028 SHALL place the state enum (IDLE/BUSY/DONE) and the default width constant (8) in the shared arithmetic package.
REQ-029 SHALL put one restoring step (compare, subtract, quotient bit) in a combinational sub-module named udiv_step, instantiated once.
REQ-030 SHALL size the step counter to ceil(log2(W+1)) bits; the datapath SHALL NOT contain a multiplier.

Verification
REQ-031 SHALL cover: dividend=1000 (0x03E8), divisor=7 -> out_valid 9 cycles after accept; quotient=142, remainder=6, both flags 0.
REQ-032 SHALL cover: dividend=65279, divisor=255 -> quotient=255, remainder=254, no flags (largest non-overflow case).
REQ-033 SHALL cover: dividend=0x1234, divisor=0 -> out_valid 1 cycle after accept; quotient=0xFF, remainder=0x34, div_by_zero=1. Also dividend=65535, divisor=255 -> quotient=0xFF, remainder=0, overflow=1.
REQ-034 SHALL cover: out_ready held low 5 cycles after out_valid -> outputs stable, in_ready low throughout; the result is consumed on the edge where out_ready=1, and in_ready=1 on the next cycle.
REQ-035 SHALL cover: rst pulsed in BUSY step 4 of 1000/7 -> immediate IDLE with all outputs 0; a following 200/9 -> quotient=22, remainder=2.
REQ-036 SHALL cover: 10,000 random back-to-back operations with random out_ready stalls -> every result matches the reference model q=d/v, r=d%v, with the flags per REQ-016 and REQ-017.

Source files
------------

// File: rtl/unsigned_16by8_div_seq_pkg.sv
// Shared definitions for the sequential 2W-by-W unsigned divider.
package unsigned_16by8_div_seq_pkg;

    localparam int DEF_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/unsigned_16by8_div_seq_if.sv
// Request/response handshake bundle between a divider client and the divider.
interface unsigned_16by8_div_seq_if #(parameter int W = 8);
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/unsigned_16by8_div_seq_udiv_step.sv
// One restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module udiv_step
    import unsigned_16by8_div_seq_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0] t;
    logic [W:0] diff;

    // rem_in < divisor keeps t below 2*divisor, so the kept result always fits in W bits
    always_comb begin
        t       = {rem_in, bit_in};
        diff    = t - {1'b0, divisor};
        q_bit   = (t >= {1'b0, divisor});
        rem_out = q_bit ? diff[W-1:0] : t[W-1:0];
    end

endmodule

// File: rtl/unsigned_16by8_div_seq.sv
// Sequential 2W-by-W unsigned restoring divider, one quotient bit per cycle.
module unsigned_16by8_div_seq
    import unsigned_16by8_div_seq_pkg::*;
#(
    parameter int W = DEF_W
) (
    input logic                     clk,
    input logic                     rst,
    unsigned_16by8_div_seq_if.slave bus
);

    localparam int CW = $clog2(W + 1);

    div_state_e    state;
    logic [W-1:0]  rem_r;
    logic [W-1:0]  lo_r;
    logic [W-1:0]  div_r;
    logic [W-1:0]  q_r;
    logic [CW-1:0] cnt;

    logic [W-1:0]  hi;
    logic [W-1:0]  step_rem;
    logic          step_q;
    logic [W-1:0]  q_next;

    assign hi     = bus.dividend[2*W-1:W];
    assign q_next = {q_r[W-2:0], step_q};

    udiv_step #(.W(W)) u_step (
        .rem_in  (rem_r),
        .bit_in  (lo_r[W-1]),
        .divisor (div_r),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rem_r           <= '0;
            lo_r            <= '0;
            div_r           <= '0;
            q_r             <= '0;
            cnt             <= '0;
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        if (bus.divisor == '0) begin
                            bus.quotient    <= '1;
                            bus.remainder   <= bus.dividend[W-1:0];
                            bus.div_by_zero <= 1'b1;
                            bus.overflow    <= 1'b0;
                            bus.out_valid   <= 1'b1;
                            state           <= DONE;
                        end else if (hi >= bus.divisor) begin
                            // quotient would need more than W bits
                            bus.quotient    <= '1;
                            bus.remainder   <= '0;
                            bus.div_by_zero <= 1'b0;
                            bus.overflow    <= 1'b1;
                            bus.out_valid   <= 1'b1;
                            state           <= DONE;
                        end else begin
                            rem_r <= hi;
                            lo_r  <= bus.dividend[W-1:0];
                            div_r <= bus.divisor;
                            q_r   <= '0;
                            cnt   <= '0;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem_r <= step_rem;
                    lo_r  <= {lo_r[W-2:0], 1'b0};
                    q_r   <= q_next;
                    cnt   <= cnt + CW'(1);
                    // last step publishes straight from the step outputs
                    if (cnt == CW'(W - 1)) begin
                        bus.quotient    <= q_next;
                        bus.remainder   <= step_rem;
                        bus.div_by_zero <= 1'b0;
                        bus.overflow    <= 1'b0;
                        bus.out_valid   <= 1'b1;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unsigned_16by8_div_seq.sv
// Randomized and directed checks of the sequential divider against an arithmetic model.
module tb_unsigned_16by8_div_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    unsigned_16by8_div_seq_if #(.W(8)) bus ();

    unsigned_16by8_div_seq #(.W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // {quotient, remainder, div_by_zero, overflow}
    function automatic logic [17:0] model(input logic [15:0] d, input logic [7:0] v);
        int unsigned qi;
        int unsigned ri;
        if (v == 8'd0) return {8'hFF, d[7:0], 1'b1, 1'b0};
        qi = int'(d) / int'(v);
        ri = int'(d) % int'(v);
        if (qi > 255) return {8'hFF, 8'h00, 1'b0, 1'b1};
        return {8'(qi), 8'(ri), 1'b0, 1'b0};
    endfunction

    function automatic logic [17:0] observed();
        return {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow};
    endfunction

    // Called just after a negedge; returns at the negedge where out_valid is first seen.
    task automatic start_op(input logic [15:0] d, input logic [7:0] v, output int lat);
        int guard;
        bus.in_valid = 1'b1;
        bus.dividend = d;
        bus.divisor  = v;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            if (lat == 0) begin
                bus.in_valid = 1'b0;
                bus.dividend = 16'($urandom);
                bus.divisor  = 8'($urandom);
            end
            lat++;
        end while (!bus.out_valid && lat < 100);
    endtask

    task automatic consume(input int stall);
        repeat (stall) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if ({bus.in_ready, bus.out_valid, observed()} !== {1'b1, 1'b0, 18'd0}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", {bus.in_ready, bus.out_valid, observed()}, {1'b1, 1'b0, 18'd0});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] dl [4] = '{16'd200, 16'd0, 16'd255, 16'h0100};
        logic [7:0]  vl [4] = '{8'd9, 8'd5, 8'd1, 8'd2};
        int lat;
        start_op(16'd1000, 8'd7, lat);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 9", lat);
        end
        checks++;
        if (observed() !== {8'd142, 8'd6, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_1000_7: got %h expected %h", observed(), {8'd142, 8'd6, 1'b0, 1'b0});
        end
        consume(0);
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL basic_consume: got %b expected 01", {bus.out_valid, bus.in_ready});
        end
        for (int i = 0; i < 4; i++) begin
            start_op(dl[i], vl[i], lat);
            checks++;
            if (observed() !== model(dl[i], vl[i])) begin
                errors++;
                $display("FAIL basic_pattern_%0d: got %h expected %h", i, observed(), model(dl[i], vl[i]));
            end
            consume(0);
        end
    endtask

    task automatic test_boundaries();
        int lat;
        start_op(16'd65279, 8'd255, lat);
        checks++;
        if (observed() !== {8'd255, 8'd254, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL max_no_overflow: got %h expected %h", observed(), {8'd255, 8'd254, 1'b0, 1'b0});
        end
        consume(0);
        start_op(16'h1234, 8'd0, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL div0_latency: got %0d expected 1", lat);
        end
        checks++;
        if (observed() !== {8'hFF, 8'h34, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL div0_result: got %h expected %h", observed(), {8'hFF, 8'h34, 1'b1, 1'b0});
        end
        consume(0);
        start_op(16'd65535, 8'd255, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL overflow_latency: got %0d expected 1", lat);
        end
        checks++;
        if (observed() !== {8'hFF, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL overflow_result: got %h expected %h", observed(), {8'hFF, 8'h00, 1'b0, 1'b1});
        end
        consume(0);
    endtask

    task automatic test_stall();
        int lat;
        logic [17:0] snap;
        start_op(16'd1000, 8'd7, lat);
        snap = observed();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.dividend = 16'($urandom);
            bus.divisor  = 8'($urandom);
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.in_ready, observed()} !== {1'b1, 1'b0, 18'({8'd142, 8'd6, 2'b00})}) begin
                errors++;
                $display("FAIL stall_hold_%0d: got %h expected %h", i, {bus.out_valid, bus.in_ready, observed()}, {1'b1, 1'b0, 8'd142, 8'd6, 2'b00});
            end
        end
        // in_valid stays high across the consuming edge; it must not be taken there
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if ({bus.out_valid, bus.in_ready, observed()} !== {1'b0, 1'b1, snap}) begin
            errors++;
            $display("FAIL stall_release: got %h expected %h", {bus.out_valid, bus.in_ready, observed()}, {1'b0, 1'b1, snap});
        end
    endtask

    task automatic test_reset_busy();
        int lat;
        bus.in_valid = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 8'd7;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, observed()} !== {1'b1, 1'b0, 18'd0}) begin
            errors++;
            $display("FAIL reset_in_busy: got %h expected %h", {bus.in_ready, bus.out_valid, observed()}, {1'b1, 1'b0, 18'd0});
        end
        @(negedge clk);
        rst = 1'b0;
        start_op(16'd200, 8'd9, lat);
        checks++;
        if ({lat[3:0], observed()} !== {4'd9, 8'd22, 8'd2, 2'b00}) begin
            errors++;
            $display("FAIL after_reset_200_9: got %h expected %h", {lat[3:0], observed()}, {4'd9, 8'd22, 8'd2, 2'b00});
        end
        consume(0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic [7:0]  v;
        logic [17:0] exp;
        int lat;
        int exp_lat;
        for (int i = 0; i < 10000; i++) begin
            d = 16'($urandom);
            v = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            exp = model(d, v);
            exp_lat = (exp[1:0] != 2'b00) ? 1 : 9;
            start_op(d, v, lat);
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL b2b_latency_%0d: got %0d expected %0d (d=%h v=%h)", i, lat, exp_lat, d, v);
            end
            checks++;
            if (observed() !== exp) begin
                errors++;
                $display("FAIL b2b_result_%0d: got %h expected %h (d=%h v=%h)", i, observed(), exp, d, v);
            end
            consume(($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3)));
        end
    endtask

    initial begin
        clk           = 1'b0;
        rst           = 1'b1;
        checks        = 0;
        errors        = 0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_boundaries();
        test_stall();
        test_reset_busy();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
